// File: rtl/gtxe2_chnl_rx_10x8dec.sv
// Two-stage 10b/8b receive decoder with running-disparity tracking and per-byte flags.
// Define GTXE2_CHNL_RX_10X8DEC_COMMA_EN to enable the RXCHARISCOMMA comma detector.
module gtxe2_chnl_rx_10x8dec #(
  parameter int iwidth = 20,
  parameter int owidth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RX8B10BEN,
  input  logic [iwidth-1:0]      data_in,
  input  logic                   valid_in,
  output logic [owidth-1:0]      data_out,
  output logic                   valid_out,
  output logic [iwidth/10-1:0]   RXCHARISK,
  output logic [iwidth/10-1:0]   RXDISPERR,
  output logic [iwidth/10-1:0]   RXNOTINTABLE,
  output logic [iwidth/10-1:0]   RXCHARISCOMMA,
  output logic                   disparity
);

  localparam int NSym = iwidth / 10;

  // Returns {legal, EDCBA} for a 6b sub-block in either disparity.
  function automatic logic [5:0] dec6(input logic [5:0] c);
    logic [5:0] r;
    case (c)
      6'b100111, 6'b011000: r = {1'b1, 5'd0};
      6'b011101, 6'b100010: r = {1'b1, 5'd1};
      6'b101101, 6'b010010: r = {1'b1, 5'd2};
      6'b110001:            r = {1'b1, 5'd3};
      6'b110101, 6'b001010: r = {1'b1, 5'd4};
      6'b101001:            r = {1'b1, 5'd5};
      6'b011001:            r = {1'b1, 5'd6};
      6'b111000, 6'b000111: r = {1'b1, 5'd7};
      6'b111001, 6'b000110: r = {1'b1, 5'd8};
      6'b100101:            r = {1'b1, 5'd9};
      6'b010101:            r = {1'b1, 5'd10};
      6'b110100:            r = {1'b1, 5'd11};
      6'b001101:            r = {1'b1, 5'd12};
      6'b101100:            r = {1'b1, 5'd13};
      6'b011100:            r = {1'b1, 5'd14};
      6'b010111, 6'b101000: r = {1'b1, 5'd15};
      6'b011011, 6'b100100: r = {1'b1, 5'd16};
      6'b100011:            r = {1'b1, 5'd17};
      6'b010011:            r = {1'b1, 5'd18};
      6'b110010:            r = {1'b1, 5'd19};
      6'b001011:            r = {1'b1, 5'd20};
      6'b101010:            r = {1'b1, 5'd21};
      6'b011010:            r = {1'b1, 5'd22};
      6'b111010, 6'b000101: r = {1'b1, 5'd23};
      6'b110011, 6'b001100: r = {1'b1, 5'd24};
      6'b100110:            r = {1'b1, 5'd25};
      6'b010110:            r = {1'b1, 5'd26};
      6'b110110, 6'b001001: r = {1'b1, 5'd27};
      6'b001110:            r = {1'b1, 5'd28};
      6'b101110, 6'b010001: r = {1'b1, 5'd29};
      6'b011110, 6'b100001: r = {1'b1, 5'd30};
      6'b101011, 6'b010100: r = {1'b1, 5'd31};
      default:              r = 6'd0;
    endcase
    return r;
  endfunction

  // Returns {legal, HGF}; D.x.7 accepts both primary and alternate forms.
  function automatic logic [3:0] dec4(input logic [3:0] c);
    logic [3:0] r;
    case (c)
      4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
      4'b1001:                            r = {1'b1, 3'd1};
      4'b0101:                            r = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
      4'b1010:                            r = {1'b1, 3'd5};
      4'b0110:                            r = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
      default:                            r = 4'd0;
    endcase
    return r;
  endfunction

  // Returns {is_k, byte} for the twelve control characters.
  function automatic logic [8:0] deck(input logic [9:0] c);
    logic [8:0] r;
    case (c)
      10'b0011110100, 10'b1100001011: r = {1'b1, 8'h1C};
      10'b0011111001, 10'b1100000110: r = {1'b1, 8'h3C};
      10'b0011110101, 10'b1100001010: r = {1'b1, 8'h5C};
      10'b0011110011, 10'b1100001100: r = {1'b1, 8'h7C};
      10'b0011110010, 10'b1100001101: r = {1'b1, 8'h9C};
      10'b0011111010, 10'b1100000101: r = {1'b1, 8'hBC};
      10'b0011110110, 10'b1100001001: r = {1'b1, 8'hDC};
      10'b0011111000, 10'b1100000111: r = {1'b1, 8'hFC};
      10'b1110101000, 10'b0001010111: r = {1'b1, 8'hF7};
      10'b1101101000, 10'b0010010111: r = {1'b1, 8'hFB};
      10'b1011101000, 10'b0100010111: r = {1'b1, 8'hFD};
      10'b0111101000, 10'b1000010111: r = {1'b1, 8'hFE};
      default:                        r = 9'd0;
    endcase
    return r;
  endfunction

  logic [iwidth-1:0] s1_data_q;
  logic              s1_en_q, s1_valid_q;
  logic [owidth-1:0] dout_q, dout_d;
  logic              valid_q;
  logic [NSym-1:0]   isk_q, isk_d, derr_q, derr_d, nit_q, nit_d;
  logic              disp_q, disp_d;
`ifdef GTXE2_CHNL_RX_10X8DEC_COMMA_EN
  logic [NSym-1:0]   comma_q, comma_d;
`endif

  logic       rd;
  logic [9:0] sym;
  int         ones;
  logic [8:0] kres;
  logic [5:0] r6;
  logic [3:0] r4;

  always_comb begin
    dout_d = dout_q;
    isk_d  = isk_q;
    derr_d = derr_q;
    nit_d  = nit_q;
    disp_d = disp_q;
`ifdef GTXE2_CHNL_RX_10X8DEC_COMMA_EN
    comma_d = comma_q;
`endif
    rd   = disp_q;
    sym  = '0;
    ones = 0;
    kres = '0;
    r6   = '0;
    r4   = '0;
    if (s1_valid_q) begin
      if (s1_en_q) begin
        for (int n = 0; n < NSym; n++) begin
          sym  = s1_data_q[n*10 +: 10];
          ones = $countones(sym);
          kres = deck(sym);
          r6   = dec6(sym[9:4]);
          r4   = dec4(sym[3:0]);
          isk_d[n]          = 1'b0;
          derr_d[n]         = 1'b0;
          nit_d[n]          = 1'b0;
          dout_d[n*8 +: 8]  = 8'h00;
          if (ones < 4 || ones > 6) begin
            nit_d[n] = 1'b1;
          end else if (kres[8]) begin
            dout_d[n*8 +: 8] = kres[7:0];
            isk_d[n]         = 1'b1;
          end else if (r6[5] && r4[3]) begin
            dout_d[n*8 +: 8] = {r4[2:0], r6[4:0]};
          end else begin
            nit_d[n] = 1'b1;
          end
          if (!nit_d[n]) derr_d[n] = (ones == 6 && rd) || (ones == 4 && !rd);
          // Disparity follows the symbol's own imbalance, even after an error.
          if (ones == 6) rd = 1'b1;
          else if (ones == 4) rd = 1'b0;
`ifdef GTXE2_CHNL_RX_10X8DEC_COMMA_EN
          comma_d[n] = isk_d[n] && (dout_d[n*8 +: 8] == 8'h3C || dout_d[n*8 +: 8] == 8'hBC ||
                                    dout_d[n*8 +: 8] == 8'hFC);
`endif
        end
        disp_d = rd;
      end else begin
        dout_d = s1_data_q[owidth-1:0];
        isk_d  = '0;
        derr_d = '0;
        nit_d  = '0;
`ifdef GTXE2_CHNL_RX_10X8DEC_COMMA_EN
        comma_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data_q  <= '0;
      s1_en_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      isk_q      <= '0;
      derr_q     <= '0;
      nit_q      <= '0;
      disp_q     <= 1'b0;
`ifdef GTXE2_CHNL_RX_10X8DEC_COMMA_EN
      comma_q    <= '0;
`endif
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_data_q <= data_in;
        s1_en_q   <= RX8B10BEN;
      end
      valid_q <= s1_valid_q;
      dout_q  <= dout_d;
      isk_q   <= isk_d;
      derr_q  <= derr_d;
      nit_q   <= nit_d;
      disp_q  <= disp_d;
`ifdef GTXE2_CHNL_RX_10X8DEC_COMMA_EN
      comma_q <= comma_d;
`endif
    end
  end

  assign data_out     = dout_q;
  assign valid_out    = valid_q;
  assign RXCHARISK    = isk_q;
  assign RXDISPERR    = derr_q;
  assign RXNOTINTABLE = nit_q;
  assign disparity    = disp_q;
`ifdef GTXE2_CHNL_RX_10X8DEC_COMMA_EN
  assign RXCHARISCOMMA = comma_q;
`else
  assign RXCHARISCOMMA = '0;
`endif

endmodule

// File: doc/gtxe2_chnl_rx_10x8dec.md
GTXE2_CHNL_RX_10X8DEC -- requirements
Module: gtxe2_chnl_rx_10x8dec

Interface
REQ-001 SHALL have parameter iwidth, default 20: encoded input width in bits, a multiple of 10.
REQ-002 SHALL have parameter owidth, default 16: decoded output width in bits, equal to iwidth*8/10.
REQ-003 SHALL have port clk, input, 1: the only clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port RX8B10BEN, input, 1: 1 = decode; 0 = the lower owidth bits of the input pass through undecoded and all flags are 0.
REQ-006 SHALL have port data_in, input, iwidth: symbol n at [n*10+9:n*10], with bit n*10+9 = 'a' and bit n*10+0 = 'j'.
REQ-007 SHALL have port valid_in, input, 1: data_in is qualified this cycle.
REQ-008 SHALL have port data_out, output, owidth: byte n at [n*8+7:n*8].
REQ-009 SHALL have port valid_out, output, 1: data_out and the flags are qualified this cycle.
REQ-010 SHALL have ports RXCHARISK, RXDISPERR, RXNOTINTABLE, output, iwidth/10 each: per-byte K-character, disparity-error and invalid-code flags.
REQ-011 SHALL have port RXCHARISCOMMA, output, iwidth/10: per-byte comma flag (see Configuration).
REQ-012 SHALL have port disparity, output, 1: current running disparity (0 = negative, 1 = positive).

Function
REQ-013 SHALL use a 2-stage pipeline: stage 1 registers data_in and valid_in; stage 2 decodes and registers outputs; latency 2 cycles, throughput one word per cycle.
REQ-014 SHALL decode symbol 0 against the running-disparity register; symbol n>0 SHALL use the disparity resulting from symbol n-1 in the same word.
REQ-015 SHALL classify each symbol by its ones count: 5 = neutral, 6 = result positive, 4 = result negative; any other count SHALL set RXNOTINTABLE.
REQ-016 SHALL set RXDISPERR when a 6-ones symbol arrives at positive disparity or a 4-ones symbol arrives at negative disparity.
REQ-017 After a disparity error, the running disparity SHALL take the symbol's resulting polarity, so that one error does not cascade.
REQ-018 SHALL set RXNOTINTABLE when the 6b or 4b sub-block is not a legal D code for either disparity and the 10b symbol is not a legal K code; for such symbols data_out = 8'h00, RXCHARISK = 0 and RXDISPERR = 0.
REQ-019 A not-in-table symbol with a 4/5/6 ones count SHALL still update the running disparity; with any other count the disparity SHALL be unchanged.
REQ-020 SHALL recognise exactly K28.0-K28.7, K23.7, K27.7, K29.7 and K30.7 in both disparities: RXCHARISK = 1 and the byte value (e.g. K28.5 = 8'hBC).
REQ-021 D.x.7 SHALL decode from both the primary (1110/0001) and alternate (0111/1000) 4b forms.
REQ-022 With valid_in low: no stage advances its data; valid_out goes low 2 cycles later; data_out, flags and disparity hold.
REQ-023 With RX8B10BEN = 0: data_out = data_in[owidth-1:0] at the same latency, and disparity holds.

Reset
REQ-024 Reset SHALL immediately clear both pipeline stages, valid_out, all flags, data_out (to 0) and disparity (to 0, negative).
REQ-025 Reset asserted mid-stream SHALL discard in-flight words: no valid_out pulse for them after release.
REQ-026 The first word accepted after reset release SHALL be decoded against negative disparity.

Configuration
REQ-027 Macro GTXE2_CHNL_RX_10X8DEC_COMMA_EN SHALL control RXCHARISCOMMA; when defined, a byte's RXCHARISCOMMA = 1 iff that byte is K28.1, K28.5 or K28.7, registered alongside RXCHARISK.
REQ-028 When GTXE2_CHNL_RX_10X8DEC_COMMA_EN is undefined, RXCHARISCOMMA SHALL be tied to 0 and no comma logic SHALL be present.

Verification
REQ-029 After reset, data_in = {1010101010, 1010101010} with valid_in = 1 SHALL give data_out = 16'hB5B5, all flags 0, disparity 0, valid_out 2 cycles later.
REQ-030 After reset, symbol 0 = 0011111010 (K28.5 RD-) and symbol 1 = 1100000101 (K28.5 RD+) SHALL give data_out = 16'hBCBC, RXCHARISK = 2'b11, RXCHARISCOMMA = 2'b11 (macro defined), RXDISPERR = 0, disparity 0.
REQ-031 After reset, two consecutive 0011111010 symbols SHALL give RXDISPERR = 2'b10, data_out = 16'hBCBC and final disparity 1.
REQ-032 Symbol 0000000000 SHALL give RXNOTINTABLE = 1 and byte 8'h00 for that symbol, with disparity unchanged.
REQ-033 Asserting reset while 2 words are in flight, then feeding one word, SHALL give no stale valid_out and exactly one valid_out decoded at negative disparity.
REQ-034 Toggling valid_in 1,0,1 SHALL give valid_out 1,0,1 delayed 2 cycles, with disparity chained across the gap.
